// File: rtl/rns_pkg.sv
// Shared constants for the redundant residue number system datapath.
// Encoder and correct/select stage both import this so the moduli never diverge.
package rns_pkg;

    localparam int NUM_DIGITS    = 10;
    localparam int NUM_REDUNDANT = 2;
    localparam int DIGIT_WIDTH   = 18;

    // Digits 9 and 10 are the redundant check digits.
    localparam int unsigned MODULUS [1:NUM_DIGITS] = '{
        32'd65536,  32'd78125,  32'd117649, 32'd177147, 32'd262027,
        32'd262049, 32'd262051, 32'd262069, 32'd262079, 32'd262103
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FIX,
        HOLD
    } state_t;

endpackage

// File: rtl/rns_digit_accum.sv
// One residue digit: serial MSB-first reduction of the magnitude modulo MODULUS,
// followed by an optional negation into the registered output digit.
module rns_digit_accum #(
    parameter int unsigned MODULUS    = 65536,
    parameter int          DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  step,
    input  logic                  bit_in,
    input  logic                  negate,
    input  logic                  load_out,
    output logic [DATA_WIDTH-1:0] residue,
    output logic [DATA_WIDTH-1:0] out_digit
);

    localparam logic [DATA_WIDTH:0]   MOD_EXT = (DATA_WIDTH+1)'(MODULUS);
    localparam logic [DATA_WIDTH-1:0] MOD_DIG = DATA_WIDTH'(MODULUS);

    logic [DATA_WIDTH:0]   doubled;
    logic [DATA_WIDTH-1:0] reduced;
    logic [DATA_WIDTH-1:0] fixed;

    // residue < MODULUS always holds, so 2*residue+1 < 2*MODULUS and one subtract suffices.
    always_comb begin
        doubled = {residue, bit_in};
        reduced = (doubled >= MOD_EXT) ? DATA_WIDTH'(doubled - MOD_EXT)
                                       : DATA_WIDTH'(doubled);
        fixed   = (negate && (residue != '0)) ? (MOD_DIG - residue) : residue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue <= '0;
        end else if (clear) begin
            residue <= '0;
        end else if (step) begin
            residue <= reduced;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_digit <= '0;
        end else if (load_out) begin
            out_digit <= fixed;
        end
    end

endmodule

// File: rtl/rns_encode10.sv
// Forward binary-to-RNS converter: signed operand in, ten residue digits out,
// reduced one magnitude bit per cycle with valid/ready handshakes on both sides.
module rns_encode10
    import rns_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int IN_WIDTH   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_1_,
    output logic [DATA_WIDTH-1:0] out_2_,
    output logic [DATA_WIDTH-1:0] out_3_,
    output logic [DATA_WIDTH-1:0] out_4_,
    output logic [DATA_WIDTH-1:0] out_5_,
    output logic [DATA_WIDTH-1:0] out_6_,
    output logic [DATA_WIDTH-1:0] out_7_,
    output logic [DATA_WIDTH-1:0] out_8_,
    output logic [DATA_WIDTH-1:0] out_9_,
    output logic [DATA_WIDTH-1:0] out_10_,
    output logic                  out_sign
);

    localparam int                CNT_W    = $clog2(IN_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(IN_WIDTH - 1);

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IN_WIDTH-1:0]   magnitude;
    logic                  accept;
    logic                  step;
    logic                  load_out;
    logic [DATA_WIDTH-1:0] digit          [1:NUM_DIGITS];
    logic [DATA_WIDTH-1:0] residue_unused [1:NUM_DIGITS];

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        step       = 1'b0;
        load_out   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) next_state = CONVERT;
            end
            CONVERT: begin
                step = 1'b1;
                if (bit_cnt == LAST_BIT) next_state = FIX;
            end
            FIX: begin
                load_out   = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Two's-complement negation maps -2^63 onto the unsigned magnitude 2^63.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            magnitude <= '0;
            out_sign  <= 1'b0;
        end else if (accept) begin
            bit_cnt   <= '0;
            out_sign  <= in_data[IN_WIDTH-1];
            magnitude <= in_data[IN_WIDTH-1] ? (~in_data + 1'b1) : in_data;
        end else if (step) begin
            bit_cnt   <= bit_cnt + 1'b1;
            magnitude <= magnitude << 1;
        end
    end

    for (genvar k = 1; k <= NUM_DIGITS; k++) begin : g_digit
        rns_digit_accum #(
            .MODULUS    (MODULUS[k]),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_accum (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (accept),
            .step      (step),
            .bit_in    (magnitude[IN_WIDTH-1]),
            .negate    (out_sign),
            .load_out  (load_out),
            .residue   (residue_unused[k]),
            .out_digit (digit[k])
        );
    end

    assign out_1_  = digit[1];
    assign out_2_  = digit[2];
    assign out_3_  = digit[3];
    assign out_4_  = digit[4];
    assign out_5_  = digit[5];
    assign out_6_  = digit[6];
    assign out_7_  = digit[7];
    assign out_8_  = digit[8];
    assign out_9_  = digit[9];
    assign out_10_ = digit[10];

endmodule
